regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and FSM state encoding for the register-file
// write arbiter and its round-robin grant sub-module.
package regfile_pkg;

    // Register-file geometry
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 1 << ADDR_W;

    // Width of the round-robin pointer and of the grantId output
    // (covers up to four requesters).
    localparam int PTR_W = 2;

    // Arbiter sequencing states; ARB is the reset state.
    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant. Priority starts at
// requester ptr and wraps modulo NUM_REQ; the first valid requester wins.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] reqValid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Scan priority slots in order ptr, ptr+1, ... and grant the first valid one.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        logic found;
        int   pos;
        grant = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && reqValid[i] && (i == pos)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares one registered register-file write port among
// NUM_REQ requesters with round-robin fairness. The optional bulk-clear
// sequence (zero every register, one per cycle) is built only when the macro
// REGFILE_ARB_CLEAR_EN is defined; otherwise clrStart is ignored and clrBusy
// stays low.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          reqValid,
    input  logic [NUM_REQ*ADDR_W-1:0]   reqAddr,
    input  logic [NUM_REQ*DATA_W-1:0]   reqData,
    output logic [NUM_REQ-1:0]          reqReady,
    input  logic                        clrStart,
    output logic                        clrBusy,
    output logic                        wrtEnable,
    output logic [ADDR_W-1:0]           wrtAddr,
    output logic [DATA_W-1:0]           wrtData,
    output logic [1:0]                  grantId
);

`ifdef REGFILE_ARB_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic                 wrt_en_q, wrt_en_d;
    logic [ADDR_W-1:0]    wrt_addr_q, wrt_addr_d;
    logic [DATA_W-1:0]    wrt_data_q, wrt_data_d;
    logic [1:0]           grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   ready;
    logic                 handshake;
    logic                 clr_fire;
    logic [1:0]           sel_id;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;

    // A clear request only has effect when the clear feature is built in.
    assign clr_fire = CLEAR_EN & clrStart;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .reqValid (reqValid),
        .ptr      (ptr_q),
        .grant    (grant)
    );

    assign handshake = |(reqValid & ready);

    // Pick the address, data and index of the granted requester.
    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_id   = 2'(i);
                sel_addr = reqAddr[i*ADDR_W +: ADDR_W];
                sel_data = reqData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state, pointer, clear counter and write-port values.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_cnt_d  = clr_cnt_q;
        wrt_en_d   = 1'b0;
        wrt_addr_d = wrt_addr_q;
        wrt_data_d = wrt_data_q;
        grant_id_d = '0;
        ready      = '0;

        unique case (state_q)
            ST_ARB: begin
                if (clr_fire) begin
                    // Clear beats requests: the first zero write (address 0)
                    // is registered on the same edge that enters CLEAR.
                    state_d    = ST_CLEAR;
                    clr_cnt_d  = '0;
                    wrt_en_d   = 1'b1;
                    wrt_addr_d = '0;
                    wrt_data_d = '0;
                end else begin
                    if (!rst) begin
                        ready = grant;
                    end
                    if (handshake) begin
                        wrt_en_d   = 1'b1;
                        wrt_addr_d = sel_addr;
                        wrt_data_d = sel_data;
                        grant_id_d = sel_id;
                        ptr_d      = (sel_id == 2'(NUM_REQ - 1)) ? '0 : sel_id + 2'd1;
                    end
                end
            end

            ST_CLEAR: begin
                // clr_cnt_q is the address currently on the write port.
                if (clr_cnt_q == '1) begin
                    state_d   = ST_ARB;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
                    wrt_en_d   = 1'b1;
                    wrt_addr_d = clr_cnt_q + ADDR_W'(1);
                    wrt_data_d = '0;
                end
            end

            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            clr_cnt_q  <= '0;
            wrt_en_q   <= 1'b0;
            wrt_addr_q <= '0;
            wrt_data_q <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_cnt_q  <= clr_cnt_d;
            wrt_en_q   <= wrt_en_d;
            wrt_addr_q <= wrt_addr_d;
            wrt_data_q <= wrt_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign reqReady  = ready;
    assign clrBusy   = (state_q == ST_CLEAR);
    assign wrtEnable = wrt_en_q;
    assign wrtAddr   = wrt_addr_q;
    assign wrtData   = wrt_data_q;
    assign grantId   = grant_id_q;

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for the register-file
// write arbiter. Clear-sequence scenarios follow REGFILE_ARB_CLEAR_EN.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      clr_start;
    logic                      clr_busy;
    logic                      wrt_enable;
    logic [ADDR_W-1:0]         wrt_addr;
    logic [DATA_W-1:0]         wrt_data;
    logic [1:0]                grant_id;

    int n_checks = 0;
    int n_fails  = 0;

    // Register-file model written from the arbiter's write port.
    logic [DATA_W-1:0] mem [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wrt_enable) mem[wrt_addr] <= wrt_data;
    end

    regfile_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (req_valid),
        .reqAddr   (req_addr),
        .reqData   (req_data),
        .reqReady  (req_ready),
        .clrStart  (clr_start),
        .clrBusy   (clr_busy),
        .wrtEnable (wrt_enable),
        .wrtAddr   (wrt_addr),
        .wrtData   (wrt_data),
        .grantId   (grant_id)
    );

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // One clock: rising edge, then settle at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        clr_start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        clr_start = 1'b0;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fails++;
            $display("FAIL reset_ready: got %b want 000", req_ready);
        end
        tick();
        n_checks++;
        if ({wrt_enable, wrt_addr, wrt_data, grant_id, clr_busy} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: en=%b addr=%0d data=%h id=%0d busy=%b want all 0",
                     wrt_enable, wrt_addr, wrt_data, grant_id, clr_busy);
        end
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(1, 3'd5, 16'hBEEF);
        req_valid = 3'b010;
        #1;
        n_checks++;
        if (req_ready !== 3'b010) begin
            n_fails++;
            $display("FAIL single_ready: got %b want 010", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (wrt_enable !== 1'b1 || wrt_addr !== 3'd5 || wrt_data !== 16'hBEEF || grant_id !== 2'd1) begin
            n_fails++;
            $display("FAIL single_write: en=%b addr=%0d data=%h id=%0d want 1/5/beef/1",
                     wrt_enable, wrt_addr, wrt_data, grant_id);
        end
        tick();
        n_checks++;
        if (wrt_enable !== 1'b0 || wrt_addr !== 3'd5 || wrt_data !== 16'hBEEF || grant_id !== 2'd0) begin
            n_fails++;
            $display("FAIL single_idle_hold: en=%b addr=%0d data=%h id=%0d want 0/5/beef/0",
                     wrt_enable, wrt_addr, wrt_data, grant_id);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'(i + 1), 16'hA000 + 16'(i));
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            logic [2:0] exp_ready;
            exp_ready = 3'b001 << (c % 3);
            #1;
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fails++;
                $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
            end
            tick();
            n_checks++;
            if (wrt_enable !== 1'b1 || grant_id !== 2'(c % 3) || wrt_data !== 16'hA000 + 16'(c % 3)
                || wrt_addr !== 3'(c % 3 + 1)) begin
                n_fails++;
                $display("FAIL fair_write[%0d]: en=%b id=%0d addr=%0d data=%h want 1/%0d/%0d/%h",
                         c, wrt_enable, grant_id, wrt_addr, wrt_data, c % 3, c % 3 + 1, 16'hA000 + 16'(c % 3));
            end
        end
        req_valid = '0;
    endtask

    // Pointer starts at 0 after fairness (last grant 2); requester 1 idle must be skipped.
    task automatic test_rr_skip();
        logic [2:0] exp_seq [3];
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b100;
        exp_seq[2] = 3'b001;
        req_valid = 3'b101;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== exp_seq[c]) begin
                n_fails++;
                $display("FAIL rr_skip[%0d]: got %b want %b", c, req_ready, exp_seq[c]);
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_same_addr();
        do_reset();
        set_req(0, 3'd6, 16'h1111);
        set_req(2, 3'd6, 16'h2222);
        req_valid = 3'b101;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fails++;
            $display("FAIL same_addr_first_ready: got %b want 001", req_ready);
        end
        tick();
        req_valid = 3'b100;
        n_checks++;
        if (wrt_enable !== 1'b1 || wrt_addr !== 3'd6 || wrt_data !== 16'h1111) begin
            n_fails++;
            $display("FAIL same_addr_first: en=%b addr=%0d data=%h want 1/6/1111", wrt_enable, wrt_addr, wrt_data);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (wrt_enable !== 1'b1 || wrt_addr !== 3'd6 || wrt_data !== 16'h2222 || grant_id !== 2'd2) begin
            n_fails++;
            $display("FAIL same_addr_second: en=%b addr=%0d data=%h id=%0d want 1/6/2222/2",
                     wrt_enable, wrt_addr, wrt_data, grant_id);
        end
        tick();
        n_checks++;
        if (mem[6] !== 16'h2222) begin
            n_fails++;
            $display("FAIL same_addr_readback: got %h want 2222", mem[6]);
        end
    endtask

`ifdef REGFILE_ARB_CLEAR_EN
    task automatic test_clear_vs_request();
        do_reset();
        // One grant to requester 1 leaves the pointer at 2.
        set_req(1, 3'd2, 16'h5555);
        req_valid = 3'b010;
        tick();
        set_req(0, 3'd1, 16'h0C0C);
        req_valid = 3'b001;
        clr_start = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fails++;
            $display("FAIL clear_beats_req: got %b want 000", req_ready);
        end
        tick();
        clr_start = 1'b0;
        for (int a = 0; a < 8; a++) begin
            // A second clrStart mid-sequence must not restart or extend it.
            clr_start = (a == 3);
            #1;
            n_checks++;
            if (clr_busy !== 1'b1 || wrt_enable !== 1'b1 || wrt_addr !== 3'(a) || wrt_data !== 16'h0000
                || grant_id !== 2'd0 || req_ready !== 3'b000) begin
                n_fails++;
                $display("FAIL clear_write[%0d]: busy=%b en=%b addr=%0d data=%h id=%0d ready=%b want 1/1/%0d/0/0/000",
                         a, clr_busy, wrt_enable, wrt_addr, wrt_data, grant_id, req_ready, a);
            end
            tick();
        end
        clr_start = 1'b0;
        #1;
        n_checks++;
        if (clr_busy !== 1'b0 || wrt_enable !== 1'b0 || req_ready !== 3'b001) begin
            n_fails++;
            $display("FAIL clear_end: busy=%b en=%b ready=%b want 0/0/001", clr_busy, wrt_enable, req_ready);
        end
        n_checks++;
        if (mem[6] !== 16'h0000 || mem[2] !== 16'h0000) begin
            n_fails++;
            $display("FAIL clear_mem: mem6=%h mem2=%h want 0/0", mem[6], mem[2]);
        end
        // Pointer preserved across the clear: with 1 and 2 valid, 2 wins.
        req_valid = 3'b110;
        #1;
        n_checks++;
        if (req_ready !== 3'b100) begin
            n_fails++;
            $display("FAIL clear_ptr_kept: got %b want 100", req_ready);
        end
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        n_checks++;
        if (wrt_enable !== 1'b1 || grant_id !== 2'd0 || wrt_addr !== 3'd1 || wrt_data !== 16'h0C0C) begin
            n_fails++;
            $display("FAIL clear_then_grant: en=%b id=%0d addr=%0d data=%h want 1/0/1/0c0c",
                     wrt_enable, grant_id, wrt_addr, wrt_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        int writes_seen;
        do_reset();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int a = 0; a < 4; a++) begin
            if (a < 3) tick();
        end
        n_checks++;
        if (wrt_addr !== 3'd3 || clr_busy !== 1'b1) begin
            n_fails++;
            $display("FAIL midclear_pos: addr=%0d busy=%b want 3/1", wrt_addr, clr_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (wrt_enable !== 1'b0 || wrt_addr !== 3'd0 || wrt_data !== 16'h0 || clr_busy !== 1'b0) begin
            n_fails++;
            $display("FAIL midclear_reset: en=%b addr=%0d data=%h busy=%b want 0/0/0/0",
                     wrt_enable, wrt_addr, wrt_data, clr_busy);
        end
        writes_seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (wrt_enable === 1'b1 || clr_busy === 1'b1) writes_seen++;
        end
        n_checks++;
        if (writes_seen !== 0) begin
            n_fails++;
            $display("FAIL midclear_no_more: got %0d write/busy cycles want 0", writes_seen);
        end
    endtask
`else
    task automatic test_clear_ignored();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'(i + 4), 16'hC000 + 16'(i));
        req_valid = 3'b111;
        clr_start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            logic [2:0] exp_ready;
            exp_ready = 3'b001 << (c % 3);
            #1;
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fails++;
                $display("FAIL noclr_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
            end
            tick();
            clr_start = 1'b0;
            n_checks++;
            if (clr_busy !== 1'b0 || wrt_enable !== 1'b1 || wrt_data !== 16'hC000 + 16'(c % 3)
                || grant_id !== 2'(c % 3)) begin
                n_fails++;
                $display("FAIL noclr_write[%0d]: busy=%b en=%b data=%h id=%0d want 0/1/%h/%0d",
                         c, clr_busy, wrt_enable, wrt_data, grant_id, 16'hC000 + 16'(c % 3), c % 3);
            end
        end
        req_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_rr_skip();
        test_same_addr();
`ifdef REGFILE_ARB_CLEAR_EN
        test_clear_vs_request();
        test_reset_mid_clear();
`else
        test_clear_ignored();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_regfile_write_arbiter
